mem_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/data_ram.sv | 29 ++
 rtl/mem_stage.sv | 60 ++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
//   DATA_W     : data word width in bits
//   ADDR_W     : width of the ALU-generated address
//   DEPTH_LOG2 : log2 of the data RAM depth in words
//   word_t     : one data word
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DEPTH_LOG2 = 10;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_ram.sv
// Single-port-write / single-port-read synchronous RAM, read-first.
// Ports:
//   clk  : rising-edge clock
//   we   : write enable, writes din to mem[addr] on this edge
//   addr : word index shared by the read and write
//   din  : write data
//   dout : registered read data (old contents when reading a word being written)
module data_ram #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned DEPTH_LOG2 = cpu_pkg::DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Both assignments are non-blocking, so dout sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data RAM indexed by the ALU result.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset (clears output, blocks writes)
//   Mem_WrEn     : store enable
//   ALU_MEM_Addr : word address; only the low DEPTH_LOG2 bits are used
//   MEM_DataIn   : store data
//   MEM_DataOut  : load data, one cycle after the address is presented
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
  parameter int unsigned DEPTH_LOG2 = cpu_pkg::DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_WrEn,
  input  logic [ADDR_W-1:0] ALU_MEM_Addr,
  input  logic [DATA_W-1:0] MEM_DataIn,
  output logic [DATA_W-1:0] MEM_DataOut
);

  logic [DEPTH_LOG2-1:0] idx;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_dout;
  logic                  clr_q;
  logic                  unused_addr_hi;

  // Upper address bits are intentionally dropped: addresses wrap.
  assign idx            = ALU_MEM_Addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^ALU_MEM_Addr[ADDR_W-1:DEPTH_LOG2];

  // A store presented while reset is asserted must not reach the RAM.
  assign ram_we = Mem_WrEn & rst_n;

  data_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_data_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (idx),
    .din  (MEM_DataIn),
    .dout (ram_dout)
  );

  // The RAM itself is never reset; a flag registered alongside its read
  // register masks the output for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_q <= 1'b1;
    end else begin
      clr_q <= 1'b0;
    end
  end

  assign MEM_DataOut = clr_q ? '0 : ram_dout;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import cpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              Mem_WrEn;
  logic [ADDR_W-1:0] ALU_MEM_Addr;
  word_t             MEM_DataIn;
  word_t             MEM_DataOut;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Mem_WrEn     (Mem_WrEn),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MEM_DataOut  (MEM_DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply current inputs across one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rn, input logic we, input logic [ADDR_W-1:0] a,
                       input word_t d);
    rst_n        = rn;
    Mem_WrEn     = we;
    ALU_MEM_Addr = a;
    MEM_DataIn   = d;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected %h", MEM_DataOut, 32'd0);
    end
  endtask

  task automatic test_basic_rw();
    drive(1'b1, 1'b1, 32'd1, 32'd5);
    step();
    drive(1'b1, 1'b0, 32'd1, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd5) begin
      n_fail++;
      $display("FAIL basic_read1: got %h expected %h", MEM_DataOut, 32'd5);
    end
  endtask

  task automatic test_signed_values();
    drive(1'b1, 1'b1, 32'd2, 32'd500);
    step();
    drive(1'b1, 1'b1, 32'd3, 32'hFFFF_FFE0);
    step();
    drive(1'b1, 1'b1, 32'd4, 32'hFFFF_FFC4);
    step();
    drive(1'b1, 1'b0, 32'd2, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd500) begin
      n_fail++;
      $display("FAIL read_addr2: got %h expected %h", MEM_DataOut, 32'd500);
    end
    drive(1'b1, 1'b0, 32'd3, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hFFFF_FFE0) begin
      n_fail++;
      $display("FAIL read_addr3: got %h expected %h", MEM_DataOut, 32'hFFFF_FFE0);
    end
    drive(1'b1, 1'b0, 32'd4, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hFFFF_FFC4) begin
      n_fail++;
      $display("FAIL read_addr4: got %h expected %h", MEM_DataOut, 32'hFFFF_FFC4);
    end
  endtask

  task automatic test_read_first();
    drive(1'b1, 1'b1, 32'd2, 32'd7);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd500) begin
      n_fail++;
      $display("FAIL read_first_old: got %h expected %h", MEM_DataOut, 32'd500);
    end
    drive(1'b1, 1'b0, 32'd2, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd7) begin
      n_fail++;
      $display("FAIL read_first_new: got %h expected %h", MEM_DataOut, 32'd7);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 32'd1025, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd5) begin
      n_fail++;
      $display("FAIL wrap_read1025: got %h expected %h", MEM_DataOut, 32'd5);
    end
    drive(1'b1, 1'b1, 32'd1025, 32'd9);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd5) begin
      n_fail++;
      $display("FAIL wrap_write_old: got %h expected %h", MEM_DataOut, 32'd5);
    end
    drive(1'b1, 1'b0, 32'd1, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd9) begin
      n_fail++;
      $display("FAIL wrap_read1: got %h expected %h", MEM_DataOut, 32'd9);
    end
    // Only the top bits set besides idx 2.
    drive(1'b1, 1'b0, 32'hFFFF_FC02, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd7) begin
      n_fail++;
      $display("FAIL wrap_high_bits: got %h expected %h", MEM_DataOut, 32'd7);
    end
  endtask

  task automatic test_reset_mid_run();
    // Output holds a nonzero word before reset.
    drive(1'b1, 1'b0, 32'd3, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hFFFF_FFE0) begin
      n_fail++;
      $display("FAIL pre_reset_read3: got %h expected %h", MEM_DataOut, 32'hFFFF_FFE0);
    end
    drive(1'b0, 1'b1, 32'd3, 32'd1);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got %h expected %h", MEM_DataOut, 32'd0);
    end
    drive(1'b1, 1'b0, 32'd3, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hFFFF_FFE0) begin
      n_fail++;
      $display("FAIL post_reset_read3: got %h expected %h", MEM_DataOut, 32'hFFFF_FFE0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF);
    step();
    drive(1'b1, 1'b1, 32'd11, 32'h1234_5678);
    step();
    drive(1'b1, 1'b0, 32'd10, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL b2b_read10: got %h expected %h", MEM_DataOut, 32'hDEAD_BEEF);
    end
    drive(1'b1, 1'b0, 32'd11, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL b2b_read11: got %h expected %h", MEM_DataOut, 32'h1234_5678);
    end
    drive(1'b1, 1'b0, 32'd4, 32'd0);
    step();
    n_checks++;
    if (MEM_DataOut !== 32'hFFFF_FFC4) begin
      n_fail++;
      $display("FAIL b2b_read4: got %h expected %h", MEM_DataOut, 32'hFFFF_FFC4);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_basic_rw();
    test_signed_values();
    test_read_first();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
